// File: rtl/io_port_responder.sv
// io_port_responder
//   Memory-mapped I/O responder on the processor data bus. A four-word
//   register window at BASE_ADDR holds debounced switches (SW), sticky
//   switch rising-edge flags (EDGE), a 7-segment display digit (DISP) and a
//   free-running prescaled timer (TIMER). Reads are combinational and writes
//   commit on the rising clock edge.
//
// Ports
//   clock       rising-edge clock for all state
//   reset       asynchronous, active-low reset
//   dmemaddr    word address from the processor
//   dmemwdata   write data
//   dmemwrite   write enable
//   dmemread    read enable
//   io_sw0/1    raw asynchronous slide switches
//   dmemrdata   read data (zero unless a read hits the window)
//   io_hit      address falls inside the window
//   io_display  active-low segments {g,f,e,d,c,b,a}
module io_port_responder #(
  parameter logic [15:0] BASE_ADDR       = 16'hFFF0,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          PRESCALE        = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  input  logic        io_sw0,
  input  logic        io_sw1,
  output logic [15:0] dmemrdata,
  output logic        io_hit,
  output logic [6:0]  io_display
);

  localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  // Window compare is done in 17 bits so a window near the top of the
  // address space never aliases onto low addresses.
  logic [1:0] reg_sel;
  assign io_hit  = ({1'b0, dmemaddr} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, dmemaddr} <= ({1'b0, BASE_ADDR} + 17'd3));
  assign reg_sel = dmemaddr[1:0] - BASE_ADDR[1:0];

  logic wr_flag, wr_disp, wr_timer;
  assign wr_flag  = dmemwrite && io_hit && (reg_sel == 2'd1);
  assign wr_disp  = dmemwrite && io_hit && (reg_sel == 2'd2);
  assign wr_timer = dmemwrite && io_hit && (reg_sel == 2'd3);

  // Switch path: two-flop synchronizer, then a debouncer that only accepts
  // a new level after it has differed from the accepted one for
  // DEBOUNCE_CYCLES consecutive cycles.
  logic [1:0] sw_raw;
  logic [1:0] sw_db;
  logic [1:0] sw_rise;
  assign sw_raw = {io_sw1, io_sw0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sw
      logic        sync1_reg;
      logic        sync2_reg;
      logic        db_reg;
      logic [15:0] cnt_reg;
      logic        settle;

      // This edge completes the required run of differing samples.
      assign settle = (sync2_reg != db_reg) && (cnt_reg == DB_LAST);

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          db_reg    <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= sw_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (settle) begin
            db_reg  <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
      end

      assign sw_db[gi]   = db_reg;
      assign sw_rise[gi] = settle && sync2_reg;
    end
  endgenerate

  // Sticky edge flags: write-one-to-clear, a simultaneous new edge wins.
  logic [1:0] flag_reg;
  logic [1:0] flag_clr;
  assign flag_clr = wr_flag ? dmemwdata[1:0] : 2'b00;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flag_reg <= 2'b00;
    end else begin
      flag_reg <= (flag_reg & ~flag_clr) | sw_rise;
    end
  end

  // Display register: [4] blank, [3:0] hex digit. Resets blank.
  logic [4:0] disp_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_reg <= 5'b10000;
    end else if (wr_disp) begin
      disp_reg <= dmemwdata[4:0];
    end
  end

  // Timer: a processor load overrides any increment due on the same edge
  // and restarts the prescale period.
  logic [15:0] timer_reg;
  logic [15:0] pre_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_reg <= '0;
      pre_reg   <= '0;
    end else if (wr_timer) begin
      timer_reg <= dmemwdata;
      pre_reg   <= '0;
    end else if (pre_reg == PRE_LAST) begin
      timer_reg <= timer_reg + 16'd1;
      pre_reg   <= '0;
    end else begin
      pre_reg   <= pre_reg + 16'd1;
    end
  end

  // Read mux: pre-edge register values, zero when no read hits the window.
  always_comb begin
    dmemrdata = 16'h0000;
    if (dmemread && io_hit) begin
      case (reg_sel)
        2'd0:    dmemrdata = {14'b0, sw_db};
        2'd1:    dmemrdata = {14'b0, flag_reg};
        2'd2:    dmemrdata = {11'b0, disp_reg};
        default: dmemrdata = timer_reg;
      endcase
    end
  end

  // Hex to active-low 7-segment {g,f,e,d,c,b,a}.
  always_comb begin
    io_display = 7'b1111111;
    if (!disp_reg[4]) begin
      case (disp_reg[3:0])
        4'h0:    io_display = 7'b1000000;
        4'h1:    io_display = 7'b1111001;
        4'h2:    io_display = 7'b0100100;
        4'h3:    io_display = 7'b0110000;
        4'h4:    io_display = 7'b0011001;
        4'h5:    io_display = 7'b0010010;
        4'h6:    io_display = 7'b0000010;
        4'h7:    io_display = 7'b1111000;
        4'h8:    io_display = 7'b0000000;
        4'h9:    io_display = 7'b0010000;
        4'hA:    io_display = 7'b0001000;
        4'hB:    io_display = 7'b0000011;
        4'hC:    io_display = 7'b1000110;
        4'hD:    io_display = 7'b0100001;
        4'hE:    io_display = 7'b0000110;
        default: io_display = 7'b0001110;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder. Two instances share the bus and switches:
// inst 0 uses DEBOUNCE_CYCLES=4, PRESCALE=1; inst 1 uses 2 and 3.
// A behavioural model predicts every output each cycle; directed phases
// add literal expectations from the register map.
module tb_io_port_responder;

  localparam logic [15:0] BASE = 16'hFFF0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dmemaddr = 16'h0000;
  logic [15:0] dmemwdata = 16'h0000;
  logic        dmemwrite = 1'b0;
  logic        dmemread = 1'b0;
  logic        io_sw0 = 1'b0;
  logic        io_sw1 = 1'b0;
  logic [15:0] rdata0, rdata1;
  logic        hit0, hit1;
  logic [6:0]  disp0, disp1;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  logic [1:0] sw_next = 2'b00;
  logic       rst_next = 1'b0;

  always #5 clock = ~clock;

  io_port_responder #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(4), .PRESCALE(1)) dut0 (
    .clock(clock), .reset(reset), .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
    .dmemwrite(dmemwrite), .dmemread(dmemread), .io_sw0(io_sw0), .io_sw1(io_sw1),
    .dmemrdata(rdata0), .io_hit(hit0), .io_display(disp0));

  io_port_responder #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(2), .PRESCALE(3)) dut1 (
    .clock(clock), .reset(reset), .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
    .dmemwrite(dmemwrite), .dmemread(dmemread), .io_sw0(io_sw0), .io_sw1(io_sw1),
    .dmemrdata(rdata1), .io_hit(hit1), .io_display(disp1));

  task automatic chk(string name, int inst, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          deb_n [2] = '{4, 2};
  int          pre_n [2] = '{1, 3};
  logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Raw switch samples from one and two edges ago (the synchronizer delay).
  logic [1:0]  m_seen1 [2], m_seen2 [2];
  logic [1:0]  m_db [2];
  int          m_streak [2][2];   // consecutive samples disagreeing with m_db
  logic [1:0]  m_flag [2];
  logic [4:0]  m_disp [2];
  logic [15:0] m_tload [2];
  int          m_tedges [2];      // edges since last load or reset

  logic [1:0]  n_seen1 [2], n_seen2 [2], n_db [2], n_flag [2];
  int          n_streak [2][2];
  logic [4:0]  n_disp [2];
  logic [15:0] n_tload [2];
  int          n_tedges [2];

  function automatic logic [15:0] m_timer(int i);
    return m_tload[i] + 16'(m_tedges[i] / pre_n[i]);
  endfunction

  function automatic bit in_window(logic [15:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 3);
  endfunction

  function automatic logic [15:0] m_reg(int i, int off);
    case (off)
      0:       return {14'b0, m_db[i]};
      1:       return {14'b0, m_flag[i]};
      2:       return {11'b0, m_disp[i]};
      default: return m_timer(i);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_seen1[i] = 2'b00; m_seen2[i] = 2'b00; m_db[i] = 2'b00;
      m_streak[i][0] = 0; m_streak[i][1] = 0;
      m_flag[i] = 2'b00; m_disp[i] = 5'b10000;
      m_tload[i] = 16'h0000; m_tedges[i] = 0;
    end
  endtask

  // Compare process: checks every cycle, then advances the model on the edge.
  initial begin
    bit          ehit;
    int          off;
    logic [15:0] erd;
    logic [6:0]  edisp;
    logic [1:0]  rise;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) model_reset();
      ehit = in_window(dmemaddr);
      off  = int'(dmemaddr) - int'(BASE);
      for (int i = 0; i < 2; i++) begin
        erd   = (dmemread && ehit) ? m_reg(i, off) : 16'h0000;
        edisp = m_disp[i][4] ? 7'b1111111 : seg_tab[m_disp[i][3:0]];
        chk("io_hit", i, {15'b0, (i == 0) ? hit0 : hit1}, {15'b0, ehit});
        chk("dmemrdata", i, (i == 0) ? rdata0 : rdata1, erd);
        chk("io_display", i, {9'b0, (i == 0) ? disp0 : disp1}, {9'b0, edisp});
        // Next state as seen after the coming edge.
        n_seen1[i] = {io_sw1, io_sw0};
        n_seen2[i] = m_seen1[i];
        n_db[i]    = m_db[i];
        rise       = 2'b00;
        for (int s = 0; s < 2; s++) begin
          if (m_seen2[i][s] == m_db[i][s]) begin
            n_streak[i][s] = 0;
          end else if (m_streak[i][s] + 1 >= deb_n[i]) begin
            n_db[i][s] = m_seen2[i][s];
            n_streak[i][s] = 0;
            rise[s] = m_seen2[i][s];
          end else begin
            n_streak[i][s] = m_streak[i][s] + 1;
          end
        end
        n_flag[i] = m_flag[i];
        if (dmemwrite && ehit && off == 1) n_flag[i] = n_flag[i] & ~dmemwdata[1:0];
        n_flag[i] = n_flag[i] | rise;
        n_disp[i] = (dmemwrite && ehit && off == 2) ? dmemwdata[4:0] : m_disp[i];
        if (dmemwrite && ehit && off == 3) begin
          n_tload[i] = dmemwdata; n_tedges[i] = 0;
        end else begin
          n_tload[i] = m_tload[i]; n_tedges[i] = m_tedges[i] + 1;
        end
      end
      @(posedge clock);
      if (reset) begin
        for (int i = 0; i < 2; i++) begin
          m_seen1[i] = n_seen1[i]; m_seen2[i] = n_seen2[i]; m_db[i] = n_db[i];
          m_streak[i][0] = n_streak[i][0]; m_streak[i][1] = n_streak[i][1];
          m_flag[i] = n_flag[i]; m_disp[i] = n_disp[i];
          m_tload[i] = n_tload[i]; m_tedges[i] = n_tedges[i];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(logic [15:0] a, logic [15:0] d, logic we, logic re);
    @(negedge clock);
    reset     = rst_next;
    io_sw0    = sw_next[0];
    io_sw1    = sw_next[1];
    dmemaddr  = a;
    dmemwdata = d;
    dmemwrite = we;
    dmemread  = re;
    #3;
    if (verbose)
      $display("t=%0t rst=%b sw=%b addr=%h we=%b wd=%h re=%b -> rd0=%h rd1=%h hit=%b disp0=%b",
               $time, reset, sw_next, a, we, d, re, rdata0, rdata1, hit0, disp0);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) access(16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    int hold [2];
    int rst_hold;
    logic [15:0] a, d;
    #1 reset = 1'b0;

    // Reset values, read while reset is held and on the release cycle.
    rst_next = 1'b0;
    access(BASE + 16'd0, 16'h0, 1'b0, 1'b1); chk("rst_sw", 0, rdata0, 16'h0000);
    access(BASE + 16'd1, 16'h0, 1'b0, 1'b1); chk("rst_edge", 0, rdata0, 16'h0000);
    access(BASE + 16'd2, 16'h0, 1'b0, 1'b1); chk("rst_disp", 0, rdata0, 16'h0010);
    chk("rst_display", 0, {9'b0, disp0}, 16'h007F);
    rst_next = 1'b1;
    access(BASE + 16'd3, 16'h0, 1'b0, 1'b1); chk("rst_timer", 0, rdata0, 16'h0000);

    // Debounce: sw0 held high appears after exactly 6 edges.
    sw_next = 2'b01;
    idle(5);
    access(BASE, 16'h0, 1'b0, 1'b1); chk("sw_5edges", 0, rdata0, 16'h0000);
    access(BASE, 16'h0, 1'b0, 1'b1); chk("sw_6edges", 0, rdata0, 16'h0001);
    access(BASE + 16'd1, 16'h0, 1'b0, 1'b1); chk("edge_sw0", 0, rdata0, 16'h0001);

    // 3-cycle glitch on sw1 is rejected by inst 0.
    sw_next = 2'b11; idle(3);
    sw_next = 2'b01; idle(8);
    access(BASE, 16'h0, 1'b0, 1'b1); chk("glitch_sw", 0, rdata0, 16'h0001);
    access(BASE + 16'd1, 16'h0, 1'b0, 1'b1); chk("glitch_edge", 0, rdata0, 16'h0001);

    // Edge clear: get both flags, clear bit 0.
    sw_next = 2'b11; idle(8);
    access(BASE + 16'd1, 16'h0, 1'b0, 1'b1); chk("edge_both", 0, rdata0, 16'h0003);
    access(BASE + 16'd1, 16'h0001, 1'b1, 1'b0);
    access(BASE + 16'd1, 16'h0, 1'b0, 1'b1); chk("edge_clr0", 0, rdata0, 16'h0002);

    // Display.
    access(BASE + 16'd2, 16'h0008, 1'b1, 1'b0);
    access(BASE + 16'd2, 16'h0, 1'b0, 1'b1); chk("disp_8", 0, {9'b0, disp0}, 16'h0000);
    access(BASE + 16'd2, 16'h0015, 1'b1, 1'b0);
    access(BASE + 16'd2, 16'h0, 1'b0, 1'b1);
    chk("disp_blank", 0, {9'b0, disp0}, 16'h007F);
    chk("disp_read", 0, rdata0, 16'h0015);

    // Timer load and wrap; inst 1 advances every 3 edges.
    access(BASE + 16'd3, 16'hFFFE, 1'b1, 1'b0);
    access(BASE + 16'd3, 16'h0, 1'b0, 1'b1);
    chk("tmr_a", 0, rdata0, 16'hFFFE); chk("tmr_a", 1, rdata1, 16'hFFFE);
    access(BASE + 16'd3, 16'h0, 1'b0, 1'b1);
    chk("tmr_b", 0, rdata0, 16'hFFFF); chk("tmr_b", 1, rdata1, 16'hFFFE);
    access(BASE + 16'd3, 16'h0, 1'b0, 1'b1);
    chk("tmr_c", 0, rdata0, 16'h0000); chk("tmr_c", 1, rdata1, 16'hFFFE);
    access(BASE + 16'd3, 16'h0, 1'b0, 1'b1);
    chk("tmr_d", 0, rdata0, 16'h0001); chk("tmr_d", 1, rdata1, 16'hFFFF);

    // Out-of-window accesses.
    access(BASE + 16'd4, 16'h0003, 1'b1, 1'b1);
    chk("oow_hi_hit", 0, {15'b0, hit0}, 16'h0000); chk("oow_hi_rd", 0, rdata0, 16'h0000);
    access(BASE - 16'd1, 16'h0003, 1'b1, 1'b1);
    chk("oow_lo_hit", 0, {15'b0, hit0}, 16'h0000); chk("oow_lo_rd", 0, rdata0, 16'h0000);
    access(BASE + 16'd2, 16'h0, 1'b0, 1'b1); chk("oow_disp", 0, rdata0, 16'h0015);

    // Reset while the timer holds 16'h1234.
    access(BASE + 16'd3, 16'h1234, 1'b1, 1'b0);
    access(BASE + 16'd3, 16'h0, 1'b0, 1'b1); chk("tmr_1234", 0, rdata0, 16'h1234);
    rst_next = 1'b0;
    access(BASE + 16'd3, 16'h0, 1'b0, 1'b1); chk("tmr_rst", 0, rdata0, 16'h0000);
    idle(2);
    rst_next = 1'b1;
    idle(1);

    // Randomized traffic checked by the model.
    verbose = 1'b0;
    hold[0] = 1; hold[1] = 1; rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int s = 0; s < 2; s++) begin
        hold[s]--;
        if (hold[s] <= 0) begin
          sw_next[s] = ~sw_next[s];
          hold[s] = $urandom_range(1, 8);
        end
      end
      if (rst_hold > 0) begin
        rst_hold--;
        rst_next = (rst_hold == 0);
      end else if ($urandom_range(0, 499) == 0) begin
        rst_hold = $urandom_range(1, 3);
        rst_next = 1'b0;
      end
      a = BASE + 16'($urandom_range(0, 5)) - 16'd1;
      d = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      access(a, d, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_responder.md
# io_port_responder

Memory-mapped I/O responder on the processor's data-memory bus. It decodes a small register window, returns read data combinationally in the same cycle, and commits writes on the clock edge. It owns debounced switch inputs, sticky edge flags, a 7-segment display register, and a free-running timer. It sits beside data RAM in the FPGA top; the top selects this block's read data whenever `io_hit` is high.

## Interface

Parameters:
- `BASE_ADDR`, 16'hFFF0: word address of register 0; the window is `BASE_ADDR`..`BASE_ADDR+3`.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before the debounced switch value changes. Valid range 1..65535.
- `PRESCALE`, 1: clock cycles per timer increment. Valid range 1..65535.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `dmemaddr`, in, 16: word address from the processor.
- `dmemwdata`, in, 16: write data.
- `dmemwrite`, in, 1: write enable.
- `dmemread`, in, 1: read enable.
- `io_sw0`, in, 1: raw, asynchronous slide switch 0.
- `io_sw1`, in, 1: raw, asynchronous slide switch 1.
- `dmemrdata`, out, 16: read data, combinational.
- `io_hit`, out, 1: high when `dmemaddr` falls inside the window, whether or not a read or write is active.
- `io_display`, out, 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation

Register map, as offsets from `BASE_ADDR`:
- +0 SW (read-only):
  - [1:0] = {sw1_db, sw0_db}; upper bits read 0.
  - Writes are ignored.
- +1 EDGE:
  - [1:0] are sticky flags, set on a rising edge of the corresponding debounced switch.
  - Writing 1 to a bit clears that flag; writing 0 leaves it unchanged.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- +2 DISP:
  - [3:0] = hex digit; [4] = blank.
  - Writes store wdata[4:0]; reads return {11'b0, disp[4:0]}.
- +3 TIMER:
  - 16-bit up counter with prescaler; reads return the current count.
  - A write loads wdata and resets the prescaler to 0.
  - If a write and an increment occur in the same cycle, the write wins.
  - The counter wraps from 16'hFFFF to 0.

Read and write behaviour:
- `dmemrdata` equals the addressed register value when `dmemread`=1 and `io_hit`=1; otherwise it is 16'h0000.
- A read and a write to the same register in the same cycle return the pre-edge value.
- Writes outside the window have no effect.
- `dmemread` and `dmemwrite` asserted together are legal; both take effect as above.

Switch path, per switch:
- Two-flop synchronizer feeds the debounce stage.
- The debounce counter clears whenever the synced value equals the debounced value.
- Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, the debounced value takes the synced value and the counter clears.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes the debounced value.

Display decoding:
- blank=1 gives `io_display`=7'b1111111.
- Otherwise the hex digit 0-F is decoded to the standard segment pattern, active-low. Examples: 0 → 7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000, F → 7'b0001110.

## Timing

Reset (`reset`=0, asynchronous):
- Synchronizers, debounced values, debounce counters, EDGE flags, TIMER and prescaler all reset to 0.
- DISP resets to 5'b10000 (blank), so `io_display`=7'b1111111.
- `dmemrdata`=0 unless a read is active.
- Reset asserted mid-debounce or mid-count discards all progress.
- Reset release is sampled on the next rising edge.

Latencies:
- Read: zero cycles; combinational from registers.
- Write: visible on the first edge; readable the cycle after.
- Switch: a raw change that stays stable reaches SW after 2 sync cycles plus `DEBOUNCE_CYCLES` cycles. The EDGE flag sets on the same edge that sw_db rises.
- Timer: with `PRESCALE`=N, the count increments once every N cycles. The first increment after reset or a load comes N edges later.

No handshake or wait states: every access completes in one cycle.

## Test plan

1. **Reset values.** Assert `reset`=0, then release. Read +0..+3 → 0, 0, 16'h0010, 0; `io_display`=7'b1111111.
2. **Debounce.** Raise `io_sw0` and hold it (`DEBOUNCE_CYCLES`=4) → SW reads 16'h0001 exactly 6 edges later, and EDGE reads 16'h0001. Separately, a 3-cycle pulse on `io_sw1` → SW[1] and EDGE[1] stay 0.
3. **Edge clear.** With EDGE=2'b11, write 16'h0001 to +1 → EDGE=2'b10. Then write 1 to bit 0 on the same cycle a new sw0 rising edge debounces → EDGE[0] stays 1.
4. **Display.** Write 16'h0008 to +2 → `io_display`=7'b0000000. Write 16'h0015 → blank, 7'b1111111, and read-back of +2 gives 16'h0015.
5. **Timer.** Write 16'hFFFE to +3 with `PRESCALE`=1 → reads give FFFE, FFFF, 0000 on successive cycles. Write on the same cycle as an increment → the loaded value wins. With `PRESCALE`=3, the count advances once every 3 edges.
6. **Decode and reset mid-operation.** Reads with `dmemaddr`=`BASE_ADDR`+4 or `BASE_ADDR`-1 → `io_hit`=0 and `dmemrdata`=0. Writes at those addresses change no register. Asserting `reset` while the timer is at 16'h1234 → it reads 0 immediately.
